gpr_wb_file: RTL and testbench

//   General-purpose register file at the far end of the write-back path.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/gpr_read_port.sv | 23 ++
 rtl/gpr_wb_file.sv | 84 ++++++++
 tb/tb_gpr_wb_file.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths and register-name constants
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
    localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/gpr_read_port.sv
// rtl/gpr_read_port.sv - one GPR read port: $0 / write-through bypass / array priority mux
module gpr_read_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_we_eff,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic [DATA_W-1:0] i_reg_data,
    output logic [DATA_W-1:0] o_data
);

    always_comb begin
        o_data = i_reg_data;
        if (i_addr == '0) begin
            o_data = '0;
        end else if (i_we_eff && (i_wb_addr == i_addr)) begin
            o_data = i_wb_data;
        end
    end

endmodule

// File: rtl/gpr_wb_file.sv
// rtl/gpr_wb_file.sv - GPR file with write-back commit, two bypassed read ports and commit trace
module gpr_wb_file #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int NREG   = cpu_pkg::NREG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] wb_pc4,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              trace_valid,
    output logic [DATA_W-1:0] trace_pc,
    output logic [ADDR_W-1:0] trace_addr,
    output logic [DATA_W-1:0] trace_data
);

    import cpu_pkg::*;

    logic [DATA_W-1:0] r_regs [NREG];
    logic              r_trace_valid;
    logic [DATA_W-1:0] r_trace_pc;
    logic [ADDR_W-1:0] r_trace_addr;
    logic [DATA_W-1:0] r_trace_data;
    logic              w_we_eff;

    // Reset also masks the write so neither storage nor the bypass sees it.
    assign w_we_eff = wb_en && (wb_addr != ADDR_W'(REG_ZERO)) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we_eff) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_trace_valid <= 1'b0;
            r_trace_pc    <= '0;
            r_trace_addr  <= '0;
            r_trace_data  <= '0;
        end else begin
            r_trace_valid <= w_we_eff;
            if (w_we_eff) begin
                r_trace_pc   <= wb_pc4 - DATA_W'(4);
                r_trace_addr <= wb_addr;
                r_trace_data <= wb_data;
            end
        end
    end

    gpr_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs_port (
        .i_addr     (rs_addr),
        .i_we_eff   (w_we_eff),
        .i_wb_addr  (wb_addr),
        .i_wb_data  (wb_data),
        .i_reg_data (r_regs[rs_addr]),
        .o_data     (rs_data)
    );

    gpr_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rt_port (
        .i_addr     (rt_addr),
        .i_we_eff   (w_we_eff),
        .i_wb_addr  (wb_addr),
        .i_wb_data  (wb_data),
        .i_reg_data (r_regs[rt_addr]),
        .o_data     (rt_data)
    );

    assign trace_valid = r_trace_valid;
    assign trace_pc    = r_trace_pc;
    assign trace_addr  = r_trace_addr;
    assign trace_data  = r_trace_data;

endmodule

// File: tb/tb_gpr_wb_file.sv
// tb/tb_gpr_wb_file.sv - directed self-checking bench for gpr_wb_file
module tb_gpr_wb_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] wb_pc4;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [4:0]  trace_addr;
    logic [31:0] trace_data;

    int n_pass  = 0;
    int n_total = 0;

    gpr_wb_file dut (
        .clk         (clk),
        .reset       (reset),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_pc4      (wb_pc4),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .trace_valid (trace_valid),
        .trace_pc    (trace_pc),
        .trace_addr  (trace_addr),
        .trace_data  (trace_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        wb_en = 1'b1; wb_addr = a; wb_data = d; wb_pc4 = p;
    endtask

    initial begin
        reset = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0; wb_pc4 = '0;
        rs_addr = '0; rt_addr = '0;
        tick();
        reset = 1'b0;

        // Preload, then reset with a write to reg31 pending in the reset cycle
        wr(5'd5, 32'hAAAA_0005, 32'h0000_1004);
        tick();
        wr(5'd31, 32'hBBBB_001F, 32'h0000_1008);
        tick();
        wb_en = 1'b0; rs_addr = 5'd5; rt_addr = 5'd31; #1;
        chk("preload_r5", rs_data, 32'hAAAA_0005);
        chk("preload_r31", rt_data, 32'hBBBB_001F);
        chk("preload_trace_pc", trace_pc, 32'h0000_1004);
        reset = 1'b1;
        wr(5'd31, 32'hCAFE_F00D, 32'h0000_100C);
        rs_addr = 5'd31; #1;
        chk("reset_no_bypass", rs_data, 32'hBBBB_001F);
        tick();
        reset = 1'b0; wb_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i); rt_addr = 5'(31 - i); #1;
            chk($sformatf("reset_rs%0d", i), rs_data, 32'h0);
            chk($sformatf("reset_rt%0d", 31 - i), rt_data, 32'h0);
        end
        chk("reset_trace_valid", 32'(trace_valid), 32'h0);
        chk("reset_trace_pc", trace_pc, 32'h0);
        chk("reset_trace_addr", 32'(trace_addr), 32'h0);
        chk("reset_trace_data", trace_data, 32'h0);

        // Write then read
        wr(5'd8, 32'h1234_5678, 32'h0000_3004);
        tick();
        wb_en = 1'b0; rs_addr = 5'd8; #1;
        chk("wr_read_r8", rs_data, 32'h1234_5678);
        chk("wr_trace_valid", 32'(trace_valid), 32'h1);
        chk("wr_trace_pc", trace_pc, 32'h0000_3000);
        chk("wr_trace_addr", 32'(trace_addr), 32'd8);
        chk("wr_trace_data", trace_data, 32'h1234_5678);

        // Same-cycle bypass on both ports
        wr(5'd9, 32'hDEAD_BEEF, 32'h0000_3008);
        rs_addr = 5'd9; rt_addr = 5'd9; #1;
        chk("byp_rs_before", rs_data, 32'hDEAD_BEEF);
        chk("byp_rt_before", rt_data, 32'hDEAD_BEEF);
        tick();
        wb_en = 1'b0; #1;
        chk("byp_rs_after", rs_data, 32'hDEAD_BEEF);
        chk("byp_rt_after", rt_data, 32'hDEAD_BEEF);
        chk("byp_trace_pc", trace_pc, 32'h0000_3004);
        chk("byp_trace_addr", 32'(trace_addr), 32'd9);

        // Bypass overrides a stale stored value on one port only
        wr(5'd8, 32'h0BAD_F00D, 32'h0000_300C);
        rs_addr = 5'd9; rt_addr = 5'd8; #1;
        chk("byp_stale_rt", rt_data, 32'h0BAD_F00D);
        chk("byp_other_rs", rs_data, 32'hDEAD_BEEF);
        tick();

        // $0 guard
        wr(5'd0, 32'hFFFF_FFFF, 32'h0000_3010);
        rs_addr = 5'd0; rt_addr = 5'd0; #1;
        chk("zero_rs_same", rs_data, 32'h0);
        chk("zero_rt_same", rt_data, 32'h0);
        tick();
        wb_en = 1'b0; #1;
        chk("zero_rs_next", rs_data, 32'h0);
        chk("zero_trace_valid", 32'(trace_valid), 32'h0);
        chk("zero_trace_pc_hold", trace_pc, 32'h0000_3008);
        chk("zero_trace_addr_hold", 32'(trace_addr), 32'd8);

        // Bubble: wb_en=0 must neither write nor bypass
        wb_en = 1'b0; wb_addr = 5'd10; wb_data = 32'd5; wb_pc4 = 32'h0000_4000;
        rs_addr = 5'd10; #1;
        chk("bubble_no_bypass", rs_data, 32'h0);
        tick();
        chk("bubble_r10", rs_data, 32'h0);
        chk("bubble_trace_valid", 32'(trace_valid), 32'h0);
        chk("bubble_trace_pc", trace_pc, 32'h0000_3008);
        chk("bubble_trace_addr", 32'(trace_addr), 32'd8);
        chk("bubble_trace_data", trace_data, 32'h0BAD_F00D);

        // Back-to-back writes to one register keep the last value
        wr(5'd10, 32'h0000_0001, 32'h0000_5004);
        tick();
        wr(5'd10, 32'h0000_0002, 32'h0000_5008);
        tick();
        wb_en = 1'b0; rs_addr = 5'd10; #1;
        chk("b2b_r10", rs_data, 32'h0000_0002);
        chk("b2b_trace_pc", trace_pc, 32'h0000_5004);

        // PC wrap
        wr(5'd29, 32'h0000_0077, 32'h0000_0000);
        tick();
        wb_en = 1'b0; rt_addr = 5'd29; #1;
        chk("wrap_trace_pc", trace_pc, 32'hFFFF_FFFC);
        chk("wrap_trace_addr", 32'(trace_addr), 32'd29);
        chk("wrap_r29", rt_data, 32'h0000_0077);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
